// File: rtl/comp_decode_serial_pkg.sv
// Shared types for the bit-serial two's-complement decoder.
// State encoding is fixed; code 2'd3 is illegal and treated as IDLE.
package comp_decode_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/comp_bit_cell.sv
// Serial magnitude cell: copy bits up to the first 1,
// invert the rest when the operand is negative.
module comp_bit_cell
  import comp_decode_serial_pkg::*;
(
  input  logic b,
  input  logic neg,
  input  logic seen_in,
  output logic m,
  output logic seen_out
);

  assign m        = neg ? (b ^ seen_in) : b;
  assign seen_out = seen_in | b;

endmodule

// File: rtl/comp_decode_serial.sv
// Two's-complement to sign/magnitude, one bit per clock,
// LSB first, fixed WIDTH-edge latency.
module comp_decode_serial
  import comp_decode_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             seen_one;
  logic [WIDTH-1:0] shift_reg;

  logic is_idle;
  logic is_run;
  logic capture;
  logic last;
  logic m;
  logic seen_nxt;

  assign is_run   = (state == ST_RUN);
  assign is_idle  = (state != ST_RUN) && (state != ST_DONE);
  assign capture  = is_idle && in_valid;
  assign last     = (cnt == CW'(WIDTH - 1));
  assign in_ready = is_idle && rst_n;
  assign busy     = !is_idle;

  comp_bit_cell u_cell (
    .b        (shift_reg[0]),
    .neg      (out_sign),
    .seen_in  (seen_one),
    .m        (m),
    .seen_out (seen_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (last) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= in_valid ? ST_RUN : ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      seen_one <= 1'b0;
    end else if (capture) begin
      cnt      <= '0;
      seen_one <= 1'b0;
    end else if (is_run) begin
      cnt      <= last ? cnt : cnt + 1'b1;
      seen_one <= seen_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
    end else if (capture) begin
      shift_reg <= in_data;
      out_sign  <= in_data[WIDTH-1];
      out_mag   <= '0;
    end else if (is_run) begin
      shift_reg <= shift_reg >> 1;
      out_mag   <= {m, out_mag[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_comp_decode_serial.sv
// Directed table, hand sequences and a random run
// against a sign/magnitude reference model.
module tb_comp_decode_serial;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  comp_decode_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         sign;
    logic [W-1:0] mag;
    int           stall;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Sends one word and checks latency, result, stall stability and
  // the handshake back to IDLE.
  task automatic send(input logic [W-1:0] d, input logic es,
                      input logic [W-1:0] em, input int stall,
                      input bit full);
    int lat;
    @(negedge clk);
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (full) chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = ~d;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (full) chk("latency", lat, W);
    chk("out_valid", out_valid, 1);
    chk("sign", out_sign, es);
    chk("mag", out_mag, em);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(negedge clk);
      if (full) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_mag", out_mag, em);
        chk("stall_in_ready", in_ready, 0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_valid", out_valid, 0);
    if (full) begin
      chk("hs_in_ready", in_ready, 1);
      chk("hs_busy", busy, 0);
    end
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] nx;
    tbl[0] = '{16'h0005, 1'b0, 16'h0005, 0};
    tbl[1] = '{16'hFFFB, 1'b1, 16'h0005, 0};
    tbl[2] = '{16'h8000, 1'b1, 16'h8000, 0};
    tbl[3] = '{16'h0000, 1'b0, 16'h0000, 0};
    tbl[4] = '{16'hFF00, 1'b1, 16'h0100, 10};
    tbl[5] = '{16'h7FFF, 1'b0, 16'h7FFF, 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sign", out_sign, 0);
    chk("rst_mag", out_mag, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    foreach (tbl[i])
      send(tbl[i].data, tbl[i].sign, tbl[i].mag, tbl[i].stall, 1'b1);

    // Reset in the middle of RUN discards the word.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    chk("run_busy", busy, 1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    begin
      int seen = 0;
      out_ready = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      out_ready = 1'b0;
      chk("no_valid_after_rst", seen, 0);
    end
    send(16'hEDCC, 1'b1, 16'h1234, 0, 1'b1);

    for (int k = 0; k < 1000; k++) begin
      x  = W'($urandom);
      nx = -x;
      send(x, x[W-1], x[W-1] ? nx : x, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
